// File: rtl/issue_hazard_ctrl.sv
// Dual-issue DC-stage scheduler: countdown scoreboard for non-bypassable
// results, shared divider sequencing, intra-pair and WAW hazard resolution.
module issue_hazard_ctrl #(
    parameter int REG_NUM  = 32,
    parameter int IDX_W    = 5,
    parameter int LOAD_LAT = 2,
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 34,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             dc_valid,
    input  logic [IDX_W-1:0] rs1_dc,
    input  logic [IDX_W-1:0] rs2_dc,
    input  logic             use_rs1_dc,
    input  logic             use_rs2_dc,
    input  logic [IDX_W-1:0] rd_dc,
    input  logic             wreg_en_dc,
    input  logic [1:0]       lat_class_dc,
    input  logic             dc_aux_valid,
    input  logic [IDX_W-1:0] rs1_dc_aux,
    input  logic [IDX_W-1:0] rs2_dc_aux,
    input  logic             use_rs1_dc_aux,
    input  logic             use_rs2_dc_aux,
    input  logic [IDX_W-1:0] rd_dc_aux,
    input  logic             wreg_en_dc_aux,
    output logic             issue_main,
    output logic             issue_aux,
    output logic             aux_split,
    output logic             stall_dc,
    output logic             div_start,
    output logic             div_busy,
    output logic             div_done
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    localparam logic [1:0] LC_LOAD = 2'd1;
    localparam logic [1:0] LC_MUL  = 2'd2;
    localparam logic [1:0] LC_DIV  = 2'd3;

    logic [CNT_W-1:0] cnt_q [REG_NUM];
    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] new_lat;

    logic main_wr, rs1_ok, rs2_ok, waw_main, div_block;
    logic rs1a_ok, rs2a_ok, pair_raw, pair_waw, aux_waw;

    always_comb begin
        new_lat = '0;
        unique case (lat_class_dc)
            LC_LOAD: new_lat = CNT_W'(LOAD_LAT - 1);
            LC_MUL:  new_lat = CNT_W'(MUL_LAT - 1);
            LC_DIV:  new_lat = CNT_W'(DIV_LAT - 1);
            default: new_lat = '0;
        endcase
    end

    assign main_wr   = wreg_en_dc & (rd_dc != '0);
    assign rs1_ok    = !use_rs1_dc | (rs1_dc == '0) | (cnt_q[rs1_dc] == '0);
    assign rs2_ok    = !use_rs2_dc | (rs2_dc == '0) | (cnt_q[rs2_dc] == '0);
    // A shorter new latency would let the older producer overwrite us.
    assign waw_main  = main_wr & (cnt_q[rd_dc] > new_lat);
    assign div_block = (lat_class_dc == LC_DIV) & (state_q != IDLE);

    assign issue_main = rst_n & dc_valid & !flush & rs1_ok & rs2_ok
                      & !waw_main & !div_block;

    assign rs1a_ok  = !use_rs1_dc_aux | (rs1_dc_aux == '0)
                    | (cnt_q[rs1_dc_aux] == '0);
    assign rs2a_ok  = !use_rs2_dc_aux | (rs2_dc_aux == '0)
                    | (cnt_q[rs2_dc_aux] == '0);
    assign pair_raw = main_wr
                    & ((use_rs1_dc_aux & (rs1_dc_aux == rd_dc))
                     | (use_rs2_dc_aux & (rs2_dc_aux == rd_dc)));
    assign pair_waw = main_wr & wreg_en_dc_aux & (rd_dc_aux == rd_dc);
    assign aux_waw  = wreg_en_dc_aux & (cnt_q[rd_dc_aux] != '0);

    assign issue_aux = issue_main & dc_aux_valid & rs1a_ok & rs2a_ok
                     & !pair_raw & !pair_waw & !aux_waw;
    assign aux_split = issue_main & dc_aux_valid & !issue_aux;
    assign stall_dc  = rst_n & dc_valid & !issue_main;
    assign div_start = issue_main & (lat_class_dc == LC_DIV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (flush)
                    cnt_q[i] <= '0;
                else if (issue_main & main_wr & (rd_dc == IDX_W'(i)))
                    cnt_q[i] <= new_lat;
                else if (cnt_q[i] != '0)
                    cnt_q[i] <= cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dcnt_d   = dcnt_q;
        div_busy = 1'b0;
        div_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (div_start) begin
                    state_d = BUSY;
                    dcnt_d  = CNT_W'(DIV_LAT - 2);
                end
            end
            BUSY: begin
                div_busy = 1'b1;
                if (dcnt_q == '0) state_d = DONE;
                else dcnt_d = dcnt_q - CNT_W'(1);
            end
            DONE: begin
                div_busy = 1'b1;
                div_done = !flush;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

endmodule
